// File: rtl/axi4_mem_pkg.sv
// rtl/axi4_mem_pkg.sv - shared constants for the AXI4 memory controller
// Purpose: response codes, default MMIO addresses and read-latency counter width.
// Ports: none (package).
package axi4_mem_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h1000_0000;
  localparam logic [31:0] PASS_ADDR_DEF    = 32'h2000_0000;

  // Width of the per-entry read latency counter (RD_LAT up to 15).
  localparam int LAT_W = 4;

endpackage

// File: rtl/axi4_mem_rdq.sv
// rtl/axi4_mem_rdq.sv - in-order read response queue with per-entry latency counters
// Purpose: holds {data, resp, latency} for accepted reads; head is presentable once its
//          counter has reached zero.
// Ports: clk, resetn; push/push_data/push_resp (enqueue); pop (dequeue head);
//        full; head_valid/head_data/head_resp (head entry view).
module axi4_mem_rdq
  import axi4_mem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RD_DEPTH = 4,
  parameter int RD_LAT   = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [1:0]        push_resp,
  input  logic              pop,
  output logic              full,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        head_resp
);

  localparam int EW = DATA_W + 2 + LAT_W;
  localparam int CW = $clog2(RD_DEPTH + 1);
  // The push cycle itself counts as the first elapsed latency cycle, so the stored
  // value is one less; the head then becomes valid exactly RD_LAT cycles after AR.
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

  logic [EW-1:0] ent_q   [RD_DEPTH];
  logic [EW-1:0] ent_d   [RD_DEPTH];
  logic [EW-1:0] shifted [RD_DEPTH];
  logic [CW-1:0] cnt_q, cnt_d, wr_idx;

  // Entry 0 is always the head; a pop shifts everything down by one.
  always_comb begin
    for (int i = 0; i < RD_DEPTH; i++) shifted[i] = '0;
    for (int i = 0; i < RD_DEPTH - 1; i++) shifted[i] = ent_q[i+1];
    wr_idx = cnt_q - CW'(pop);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    for (int i = 0; i < RD_DEPTH; i++) begin
      ent_d[i] = pop ? shifted[i] : ent_q[i];
      if (ent_d[i][LAT_W-1:0] != '0) ent_d[i][LAT_W-1:0] = ent_d[i][LAT_W-1:0] - LAT_W'(1);
      if (push && (CW'(i) == wr_idx)) ent_d[i] = {push_data, push_resp, LAT_INIT};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      for (int i = 0; i < RD_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < RD_DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign full       = (cnt_q == CW'(RD_DEPTH));
  assign head_valid = (cnt_q != '0) && (ent_q[0][LAT_W-1:0] == '0);
  assign head_data  = ent_q[0][EW-1 -: DATA_W];
  assign head_resp  = ent_q[0][LAT_W +: 2];

endmodule

// File: rtl/axi4_mem_ctrl.sv
// rtl/axi4_mem_ctrl.sv - AXI4-lite style memory slave with console and test-pass MMIO
// Purpose: word-addressed backing store with byte strobes, a byte console register and a
//          sticky tests_passed flag; reads return in order after a fixed latency.
// Ports: clk, resetn; AW (awvalid/awready/awaddr/awprot); W (wvalid/wready/wdata/wstrb);
//        B (bvalid/bready/bresp); AR (arvalid/arready/araddr/arprot);
//        R (rvalid/rready/rdata/rresp); console_valid/console_data; tests_passed.
module axi4_mem_ctrl
  import axi4_mem_pkg::*;
#(
  parameter int          DATA_W       = 32,
  parameter int          MEM_BYTES    = 65536,
  parameter int          RD_DEPTH     = 4,
  parameter int          RD_LAT       = 2,
  parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
  parameter logic [31:0] PASS_ADDR    = PASS_ADDR_DEF,
  parameter logic [31:0] PASS_VALUE   = 32'd123456789
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                awvalid,
  output logic                awready,
  input  logic [31:0]         awaddr,
  input  logic [2:0]          awprot,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp,
  input  logic                arvalid,
  output logic                arready,
  input  logic [31:0]         araddr,
  input  logic [2:0]          arprot,
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                console_valid,
  output logic [7:0]          console_data,
  output logic                tests_passed
);

  localparam int          BYTES     = DATA_W / 8;
  localparam int          BO        = $clog2(BYTES);
  localparam int          WORDS     = MEM_BYTES / BYTES;
  localparam int          IW        = $clog2(WORDS);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
  localparam logic [31:0] ADDR_MASK = ~(32'(BYTES) - 32'd1);

  logic [DATA_W-1:0] mem [WORDS];

  logic              aw_full_q, w_full_q, bvalid_q, console_valid_q, tests_passed_q;
  logic [31:0]       aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [BYTES-1:0]  w_strb_q;
  logic [1:0]        bresp_q;
  logic [7:0]        console_data_q;

  logic              aw_hs, w_hs, ar_hs, commit, rdq_full;
  logic              w_mem, w_con, w_pass, r_mem;
  logic [31:0]       wa, ra;
  logic [DATA_W-1:0] r_word;
  logic              unused_prot;

  assign unused_prot = ^{awprot, arprot};

  // Readies are gated by resetn so they read 0 while reset is held and rise as soon as
  // it is released.
  assign awready = resetn & ~aw_full_q;
  assign wready  = resetn & ~w_full_q;
  assign arready = resetn & ~rdq_full;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign ar_hs = arvalid & arready;

  // A pending B response blocks the next commit unless it is being taken this cycle.
  assign commit = aw_full_q & w_full_q & (~bvalid_q | bready);

  assign wa     = aw_addr_q & ADDR_MASK;
  assign w_mem  = wa < MEM_LIMIT;
  assign w_con  = ~w_mem & (wa == (CONSOLE_ADDR & ADDR_MASK));
  assign w_pass = ~w_mem & ~w_con & (wa == (PASS_ADDR & ADDR_MASK));

  assign ra     = araddr & ADDR_MASK;
  assign r_mem  = ra < MEM_LIMIT;
  // Memory is read before this edge's write lands, so a same-cycle read sees old data.
  assign r_word = r_mem ? mem[araddr[BO +: IW]] : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_full_q       <= 1'b0;
      aw_addr_q       <= '0;
      w_full_q        <= 1'b0;
      w_data_q        <= '0;
      w_strb_q        <= '0;
      bvalid_q        <= 1'b0;
      bresp_q         <= RESP_OKAY;
      console_valid_q <= 1'b0;
      console_data_q  <= '0;
      tests_passed_q  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= awaddr;
      end else if (commit) begin
        aw_full_q <= 1'b0;
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end else if (commit) begin
        w_full_q <= 1'b0;
      end
      console_valid_q <= commit & w_con;
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (w_mem | w_con | w_pass) ? RESP_OKAY : RESP_DECERR;
        if (w_con) console_data_q <= w_data_q[7:0];
        if (w_pass && (w_data_q == DATA_W'(PASS_VALUE))) tests_passed_q <= 1'b1;
      end else if (bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && w_mem) begin
      for (int b = 0; b < BYTES; b++)
        if (w_strb_q[b]) mem[aw_addr_q[BO +: IW]][8*b +: 8] <= w_data_q[8*b +: 8];
    end
  end

  axi4_mem_rdq #(
    .DATA_W  (DATA_W),
    .RD_DEPTH(RD_DEPTH),
    .RD_LAT  (RD_LAT)
  ) u_rdq (
    .clk       (clk),
    .resetn    (resetn),
    .push      (ar_hs),
    .push_data (r_word),
    .push_resp (r_mem ? RESP_OKAY : RESP_DECERR),
    .pop       (rvalid & rready),
    .full      (rdq_full),
    .head_valid(rvalid),
    .head_data (rdata),
    .head_resp (rresp)
  );

  assign bvalid        = bvalid_q;
  assign bresp         = bresp_q;
  assign console_valid = console_valid_q;
  assign console_data  = console_data_q;
  assign tests_passed  = tests_passed_q;

endmodule

// File: tb/tb_axi4_mem_ctrl.sv
// tb/tb_axi4_mem_ctrl.sv - self-checking bench for axi4_mem_ctrl
module tb_axi4_mem_ctrl;

  localparam int          RD_DEPTH = 4;
  localparam int          RD_LAT   = 2;
  localparam int          MEMB     = 65536;
  localparam logic [31:0] CON_A    = 32'h1000_0000;
  localparam logic [31:0] PASS_A   = 32'h2000_0000;
  localparam logic [31:0] PASS_V   = 32'd123456789;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] awaddr = 0, araddr = 0, wdata = 0;
  logic [2:0]  awprot = 0, arprot = 0;
  logic [3:0]  wstrb = 0;
  logic        awready, wready, bvalid, arready, rvalid, console_valid, tests_passed;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [7:0]  console_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] model [0:63];
  int         cv_cycles = 0;
  logic [7:0] cv_last = 8'h00;

  always #5 clk = ~clk;

  axi4_mem_ctrl #(
    .DATA_W(32), .MEM_BYTES(MEMB), .RD_DEPTH(RD_DEPTH), .RD_LAT(RD_LAT),
    .CONSOLE_ADDR(CON_A), .PASS_ADDR(PASS_A), .PASS_VALUE(PASS_V)
  ) dut (
    .clk(clk), .resetn(resetn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .console_valid(console_valid), .console_data(console_data), .tests_passed(tests_passed)
  );

  always @(negedge clk) begin
    if (console_valid) begin
      cv_cycles = cv_cycles + 1;
      cv_last   = console_data;
    end
  end

  function automatic logic [31:0] exp_word(input int idx);
    return {model[idx*4+3], model[idx*4+2], model[idx*4+1], model[idx*4]};
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a[5:2]);
    for (int b = 0; b < 4; b++) if (s[b]) model[idx*4+b] = d[8*b +: 8];
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    logic aw_hs, w_hs;
    awaddr = a; wdata = d; wstrb = s; awprot = 3'($urandom);
    awvalid = 1; wvalid = 1; bready = 1; resp = 2'b01; n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1; n++;
      if (aw_hs) awvalid = 0;
      if (w_hs) wvalid = 0;
    end
    n = 0;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!bvalid) begin
      n_cmp++; n_bad++;
      $display("FAIL write_timeout addr=%h: no B response within 50 cycles", a);
      awvalid = 0; wvalid = 0;
    end else resp = bresp;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    logic hs;
    araddr = a; arprot = 3'($urandom); arvalid = 1; rready = 1;
    d = 32'hFFFF_FFFF; resp = 2'b01; n = 0;
    while (arvalid && n < 50) begin
      hs = arready;
      @(posedge clk); #1; n++;
      if (hs) arvalid = 0;
    end
    n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!rvalid) begin
      n_cmp++; n_bad++;
      $display("FAIL read_timeout addr=%h: no R beat within 50 cycles", a);
      arvalid = 0;
    end else begin
      d = rdata; resp = rresp;
    end
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic test_reset();
    #2 resetn = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({awready, wready, arready, bvalid, rvalid, console_valid, tests_passed} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b required 0000000",
               {awready, wready, arready, bvalid, rvalid, console_valid, tests_passed});
    end
    n_cmp++;
    if ({bresp, rresp, rdata, console_data} !== 44'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h required 0", {bresp, rresp, rdata, console_data});
    end
    resetn = 1;
    #1;
    n_cmp++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_bad++;
      $display("FAIL ready_after_reset: got %b required 111", {awready, wready, arready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_init_region();
    logic [1:0] rs;
    for (int i = 0; i < 16; i++) begin
      axi_write(32'(i * 4), 32'h0, 4'hF, rs);
      model_write(32'(i * 4), 32'h0, 4'hF);
      n_cmp++;
      if (rs !== 2'b00) begin
        n_bad++;
        $display("FAIL init_bresp word %0d: got %b required 00", i, rs);
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0]  rs;
    logic [31:0] rd;
    axi_write(32'h10, 32'hDEAD_BEEF, 4'b0101, rs);
    model_write(32'h10, 32'hDEAD_BEEF, 4'b0101);
    n_cmp++;
    if (rs !== 2'b00) begin n_bad++; $display("FAIL strobe_bresp: got %b required 00", rs); end
    axi_read(32'h10, rd, rs);
    n_cmp++;
    if (rd !== 32'h00AD_00EF || rs !== 2'b00) begin
      n_bad++;
      $display("FAIL strobe_read: got %h/%b required 00ad00ef/00", rd, rs);
    end
    axi_read(32'h13, rd, rs);
    n_cmp++;
    if (rd !== 32'h00AD_00EF) begin
      n_bad++;
      $display("FAIL unaligned_read: got %h required 00ad00ef", rd);
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d;
    logic        hs;
    int          extra;
    d = $urandom; bready = 0;
    wdata = d; wstrb = 4'hF; wvalid = 1;
    hs = wready;
    @(posedge clk); #1;
    wvalid = 0;
    n_cmp++;
    if (hs !== 1'b1) begin n_bad++; $display("FAIL w_accept: got %b required 1", hs); end
    repeat (2) begin
      n_cmp++;
      if ({wready, bvalid} !== 2'b00) begin
        n_bad++;
        $display("FAIL w_only_hold: wready/bvalid got %b required 00", {wready, bvalid});
      end
      @(posedge clk); #1;
    end
    awaddr = 32'h8 | 32'($urandom_range(0, 3)); awvalid = 1;
    hs = awready;
    @(posedge clk); #1;
    awvalid = 0;
    n_cmp++;
    if (hs !== 1'b1 || bvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL aw_accept: awready/bvalid got %b%b required 10", hs, bvalid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      n_bad++;
      $display("FAIL bvalid_rise: got %b/%b required 1/00", bvalid, bresp);
    end
    model_write(32'h8, d, 4'hF);
    @(posedge clk); #1;
    n_cmp++;
    if (bvalid !== 1'b1) begin n_bad++; $display("FAIL bvalid_hold: got %b required 1", bvalid); end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    extra = 0;
    repeat (4) begin
      if (bvalid) extra++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (extra != 0 || {awready, wready} !== 2'b11) begin
      n_bad++;
      $display("FAIL single_commit: extra bvalid cycles %0d, readies %b required 0, 11",
               extra, {awready, wready});
    end
  endtask

  task automatic test_read_queue();
    int   acc, beats, first_rv, n;
    logic hs, rhs;
    rready = 0; arvalid = 1; araddr = 0; acc = 0; first_rv = -1;
    for (int cyc = 0; cyc < RD_DEPTH + 3; cyc++) begin
      if (rvalid && first_rv < 0) first_rv = cyc;
      if (cyc >= RD_DEPTH) begin
        n_cmp++;
        if (arready !== 1'b0) begin
          n_bad++;
          $display("FAIL arready_full cycle %0d: got %b required 0", cyc, arready);
        end
      end
      hs = arvalid && arready;
      @(posedge clk); #1;
      if (hs) begin acc++; araddr = 32'(acc * 4); end
    end
    n_cmp++;
    if (acc != RD_DEPTH) begin n_bad++; $display("FAIL accepted: got %0d required %0d", acc, RD_DEPTH); end
    n_cmp++;
    if (first_rv != RD_LAT) begin
      n_bad++;
      $display("FAIL first_beat_latency: got %0d required %0d", first_rv, RD_LAT);
    end
    rready = 1; beats = 0; n = 0;
    while (beats < RD_DEPTH + 1 && n < 100) begin
      hs  = arvalid && arready;
      rhs = rvalid;
      if (rhs) begin
        n_cmp++;
        if (rdata !== exp_word(beats) || rresp !== 2'b00) begin
          n_bad++;
          $display("FAIL rd_order beat %0d: got %h/%b required %h/00", beats, rdata, rresp, exp_word(beats));
        end
      end
      @(posedge clk); #1; n++;
      if (hs) begin
        acc++; araddr = 32'(acc * 4);
        if (acc == RD_DEPTH + 1) arvalid = 0;
      end
      if (rhs) beats++;
    end
    arvalid = 0; rready = 0;
    n_cmp++;
    if (beats != RD_DEPTH + 1) begin
      n_bad++;
      $display("FAIL drain: got %0d beats required %0d", beats, RD_DEPTH + 1);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd;
    logic [3:0]  s;
    logic [1:0]  rs;
    int          idx;
    for (int it = 0; it < 30; it++) begin
      idx = $urandom_range(0, 15);
      a = 32'(idx * 4) | 32'($urandom_range(0, 3));
      d = $urandom; s = 4'($urandom);
      axi_write(a, d, s, rs);
      model_write(a, d, s);
      n_cmp++;
      if (rs !== 2'b00) begin n_bad++; $display("FAIL rand_bresp it %0d: got %b required 00", it, rs); end
      idx = $urandom_range(0, 15);
      axi_read(32'(idx * 4) | 32'($urandom_range(0, 3)), rd, rs);
      n_cmp++;
      if (rd !== exp_word(idx) || rs !== 2'b00) begin
        n_bad++;
        $display("FAIL rand_read word %0d: got %h/%b required %h/00", idx, rd, rs, exp_word(idx));
      end
    end
  endtask

  task automatic test_read_during_commit();
    logic [31:0] old, d, rd;
    logic [1:0]  rs;
    logic        hs;
    int          idx, n;
    idx = $urandom_range(0, 15);
    old = exp_word(idx); d = ~old;
    awaddr = 32'(idx * 4); wdata = d; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    hs = awready && wready;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    araddr = 32'(idx * 4); arvalid = 1; rready = 1;
    n_cmp++;
    if (hs !== 1'b1 || arready !== 1'b1) begin
      n_bad++;
      $display("FAIL hazard_setup: aw/w ready %b arready %b required 1 1", hs, arready);
    end
    @(posedge clk); #1;
    arvalid = 0; n = 0;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== old) begin
      n_bad++;
      $display("FAIL read_old_data: got %b/%h required 1/%h", rvalid, rdata, old);
    end
    @(posedge clk); #1;
    rready = 0; bready = 0;
    model_write(32'(idx * 4), d, 4'hF);
    axi_read(32'(idx * 4), rd, rs);
    n_cmp++;
    if (rd !== d) begin n_bad++; $display("FAIL read_new_data: got %h required %h", rd, d); end
  endtask

  task automatic test_mmio();
    logic [1:0] rs;
    int         c0;
    c0 = cv_cycles;
    axi_write(CON_A, (32'($urandom) << 8) | 32'h41, 4'hF, rs);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (rs !== 2'b00 || cv_cycles - c0 != 1 || cv_last !== 8'h41) begin
      n_bad++;
      $display("FAIL console: bresp %b pulse cycles %0d data %h required 00 1 41", rs, cv_cycles - c0, cv_last);
    end
    axi_write(PASS_A, PASS_V + 32'd1, 4'hF, rs);
    n_cmp++;
    if (tests_passed !== 1'b0 || rs !== 2'b00) begin
      n_bad++;
      $display("FAIL pass_wrong_value: tests_passed %b bresp %b required 0 00", tests_passed, rs);
    end
    axi_write(PASS_A, PASS_V, 4'hF, rs);
    n_cmp++;
    if (tests_passed !== 1'b1) begin n_bad++; $display("FAIL pass_set: got %b required 1", tests_passed); end
    axi_write(PASS_A, 32'h0, 4'hF, rs);
    n_cmp++;
    if (tests_passed !== 1'b1) begin n_bad++; $display("FAIL pass_sticky: got %b required 1", tests_passed); end
  endtask

  task automatic test_decerr();
    logic [31:0] rd;
    logic [1:0]  rs;
    axi_read(32'h3000_0000, rd, rs);
    n_cmp++;
    if (rd !== 32'h0 || rs !== 2'b11) begin
      n_bad++;
      $display("FAIL oor_read: got %h/%b required 0/11", rd, rs);
    end
    axi_write(32'h3000_0010, 32'hFFFF_FFFF, 4'hF, rs);
    n_cmp++;
    if (rs !== 2'b11) begin n_bad++; $display("FAIL oor_write_bresp: got %b required 11", rs); end
    axi_read(32'h10, rd, rs);
    n_cmp++;
    if (rd !== exp_word(4)) begin
      n_bad++;
      $display("FAIL oor_write_alias: got %h required %h", rd, exp_word(4));
    end
    axi_read(CON_A, rd, rs);
    n_cmp++;
    if (rd !== 32'h0 || rs !== 2'b11) begin
      n_bad++;
      $display("FAIL mmio_read: got %h/%b required 0/11", rd, rs);
    end
    axi_read(32'(MEMB), rd, rs);
    n_cmp++;
    if (rs !== 2'b11) begin n_bad++; $display("FAIL limit_read: got %b required 11", rs); end
    axi_write(32'(MEMB - 4), 32'hA5C3_0F1E, 4'hF, rs);
    axi_read(32'(MEMB - 4), rd, rs);
    n_cmp++;
    if (rd !== 32'hA5C3_0F1E || rs !== 2'b00) begin
      n_bad++;
      $display("FAIL last_word: got %h/%b required a5c30f1e/00", rd, rs);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, rd;
    logic [1:0]  rs;
    logic        hs;
    int          acc, n, rv, bv;
    awaddr = 32'h3C; awvalid = 1;
    hs = awready;
    @(posedge clk); #1;
    awvalid = 0;
    rready = 0; araddr = 0; arvalid = 1; acc = 0; n = 0;
    while (acc < 2 && n < 20) begin
      hs = arready;
      @(posedge clk); #1; n++;
      if (hs) acc++;
    end
    arvalid = 0;
    repeat (RD_LAT) @(posedge clk);
    #1;
    n_cmp++;
    if (rvalid !== 1'b1) begin n_bad++; $display("FAIL queued_before_reset: rvalid %b required 1", rvalid); end
    resetn = 0;
    #1;
    n_cmp++;
    if ({rvalid, arready, awready, wready} !== 4'b0) begin
      n_bad++;
      $display("FAIL async_reset: rvalid/arready/awready/wready got %b required 0000",
               {rvalid, arready, awready, wready});
    end
    @(posedge clk); @(posedge clk); #1;
    resetn = 1; rready = 1;
    d = $urandom; wdata = d; wstrb = 4'hF; wvalid = 1; bready = 1;
    rv = 0; bv = 0;
    for (int c = 0; c < 8; c++) begin
      hs = wready;
      if (rvalid) rv++;
      if (bvalid) bv++;
      @(posedge clk); #1;
      if (hs) wvalid = 0;
    end
    wvalid = 0; rready = 0;
    n_cmp++;
    if (rv != 0 || bv != 0) begin
      n_bad++;
      $display("FAIL discard_inflight: rvalid cycles %0d bvalid cycles %0d required 0 0", rv, bv);
    end
    awaddr = 32'h3C; awvalid = 1; n = 0;
    while (awvalid && n < 20) begin
      hs = awready;
      @(posedge clk); #1; n++;
      if (hs) awvalid = 0;
    end
    n = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    n_cmp++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      n_bad++;
      $display("FAIL post_reset_write: bvalid/bresp got %b/%b required 1/00", bvalid, bresp);
    end
    awvalid = 0;
    @(posedge clk); #1;
    bready = 0;
    model_write(32'h3C, d, 4'hF);
    axi_read(32'h3C, rd, rs);
    n_cmp++;
    if (rd !== d) begin n_bad++; $display("FAIL post_reset_data: got %h required %h", rd, d); end
    axi_read(32'h10, rd, rs);
    n_cmp++;
    if (rd !== exp_word(4)) begin
      n_bad++;
      $display("FAIL mem_retained: got %h required %h", rd, exp_word(4));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init_region();
    test_strobe();
    test_w_before_aw();
    test_read_queue();
    test_random();
    test_read_during_commit();
    test_mmio();
    test_decerr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
